// File: rtl/pwm_timebase.sv
// PWM time base: fixed pre-divider, shadowed 8-bit prescaler and shared phase counter.
// state | meaning:  ST_STOP | counters held at 0, waiting for sleep=0;  ST_RUN | time base counting
module pwm_timebase #(
  parameter int BASE_DIV = 10,
  parameter int CNT_W    = 12,
  parameter int PRE_MIN  = 3,
  parameter int PRE_RST  = 30
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             sleep,
  input  logic             prescale_wr,
  input  logic [7:0]       prescale_in,
  output logic [CNT_W-1:0] pwm_cnt,
  output logic             step,
  output logic             cycle_start,
  output logic             running,
  output logic [7:0]       pre_active
);

  localparam int                BASE_W    = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [7:0]        PRE_MIN_B = 8'(PRE_MIN);
  localparam logic [7:0]        PRE_RST_B = 8'(PRE_RST);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [BASE_W-1:0] r_base, w_base_nxt;
  logic [7:0]        r_pre, w_pre_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_step, w_step_nxt;
  logic              r_cs, w_cs_nxt;
  logic [7:0]        r_act, w_act_nxt;
  logic              r_pend, w_pend_nxt;
  logic [7:0]        r_pval, w_pval_nxt;
  logic [7:0]        w_pre_clamped;
  logic              w_step_cond;

  assign w_pre_clamped = (prescale_in < PRE_MIN_B) ? PRE_MIN_B : prescale_in;
  assign w_step_cond   = (r_base == BASE_LAST) && (r_pre == r_act);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state <= ST_STOP;
      r_base  <= '0;
      r_pre   <= '0;
      r_cnt   <= '0;
      r_step  <= 1'b0;
      r_cs    <= 1'b0;
      r_act   <= PRE_RST_B;
      r_pend  <= 1'b0;
      r_pval  <= PRE_RST_B;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_pre   <= w_pre_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_cs    <= w_cs_nxt;
      r_act   <= w_act_nxt;
      r_pend  <= w_pend_nxt;
      r_pval  <= w_pval_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_pre_nxt   = r_pre;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;
    w_cs_nxt    = 1'b0;
    w_act_nxt   = r_act;
    w_pend_nxt  = r_pend;
    w_pval_nxt  = r_pval;

    case (r_state)
      ST_STOP: begin
        w_base_nxt = '0;
        w_pre_nxt  = '0;
        w_cnt_nxt  = '0;
        if (!sleep) begin
          w_state_nxt = ST_RUN;
          w_cs_nxt    = 1'b1;
        end
        if (r_pend) begin
          w_act_nxt  = r_pval;
          w_pend_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        if (sleep) begin
          w_state_nxt = ST_STOP;
          w_base_nxt  = '0;
          w_pre_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_base_nxt = (r_base == BASE_LAST) ? '0 : r_base + 1'b1;
          if (r_base == BASE_LAST)
            w_pre_nxt = (r_pre == r_act) ? 8'd0 : r_pre + 8'd1;
          if (w_step_cond) begin
            w_cnt_nxt  = r_cnt + 1'b1;
            w_step_nxt = 1'b1;
            // New prescale only lands where a fresh PWM cycle begins.
            if (r_cnt == CNT_MAX) begin
              w_cs_nxt = 1'b1;
              if (r_pend) begin
                w_act_nxt  = r_pval;
                w_pend_nxt = 1'b0;
              end
            end
          end
        end
      end
      default: w_state_nxt = ST_STOP;
    endcase

    // A write on an apply edge stays pending; the value applied was the older one.
    if (prescale_wr) begin
      w_pend_nxt = 1'b1;
      w_pval_nxt = w_pre_clamped;
    end
  end

  assign pwm_cnt     = r_cnt;
  assign step        = r_step;
  assign cycle_start = r_cs;
  assign running     = (r_state == ST_RUN);
  assign pre_active  = r_act;

endmodule

// File: tb/tb_pwm_timebase.sv
// Directed bench for pwm_timebase: expected step/cycle_start events are queued
// as stimulus is applied and matched against DUT pulses as they appear.
module tb_pwm_timebase;

  logic       clkin = 1'b0;
  logic       reset = 1'b0;
  logic       sleep = 1'b0;
  logic       prescale_wr = 1'b0;
  logic [7:0] prescale_in = 8'd0;
  logic [3:0] pwm_cnt;
  logic       step, cycle_start, running;
  logic [7:0] pre_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_evt = 0;

  typedef struct {
    string tag;
    int    gap;
    int    cnt;
    int    cs;
    int    stp;
    int    pre;
  } exp_t;

  exp_t sb[$];

  pwm_timebase #(.BASE_DIV(2), .CNT_W(4), .PRE_MIN(3), .PRE_RST(30)) dut (
    .clkin(clkin), .reset(reset), .sleep(sleep),
    .prescale_wr(prescale_wr), .prescale_in(prescale_in),
    .pwm_cnt(pwm_cnt), .step(step), .cycle_start(cycle_start),
    .running(running), .pre_active(pre_active)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int gap, input int cnt, input int cs,
                      input int stp, input int pre);
    exp_t e;
    e.tag = tag; e.gap = gap; e.cnt = cnt; e.cs = cs; e.stp = stp; e.pre = pre;
    sb.push_back(e);
  endtask

  task automatic push_steps(input string tag, input int first, input int last,
                            input int gap, input int pre);
    for (int k = first; k <= last; k++)
      push($sformatf("%s cnt%0d", tag, k), gap, k, 0, 1, pre);
  endtask

  task automatic drain();
    exp_t e;
    int   n;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n = 0;
      do begin
        @(negedge clkin);
        n++;
      end while (!(step || cycle_start) && n < e.gap + 4);
      if (!(step || cycle_start)) begin
        check({e.tag, " timeout"}, 32'(step | cycle_start), 1);
      end else begin
        check({e.tag, " gap"}, cyc - last_evt, e.gap);
        check({e.tag, " pwm_cnt"}, pwm_cnt, e.cnt);
        check({e.tag, " cycle_start"}, cycle_start, e.cs);
        check({e.tag, " step"}, step, e.stp);
        check({e.tag, " pre_active"}, pre_active, e.pre);
      end
      last_evt = cyc;
    end
  endtask

  task automatic wr_pre(input logic [7:0] val);
    prescale_wr = 1'b1;
    prescale_in = val;
    @(negedge clkin);
    prescale_wr = 1'b0;
  endtask

  initial begin
    int ev;
    #1 reset = 1'b1;
    repeat (2) @(negedge clkin);
    check("rst pwm_cnt", pwm_cnt, 0);
    check("rst step", step, 0);
    check("rst cycle_start", cycle_start, 0);
    check("rst running", running, 0);
    check("rst pre_active", pre_active, 30);

    // Reset release with default prescale 30: step every 62, cycle every 992.
    reset = 1'b0;
    last_evt = cyc;
    push("t1 start", 1, 0, 1, 0, 30);
    push_steps("t1", 1, 15, 62, 30);
    push("t1 wrap", 62, 0, 1, 1, 30);
    drain();
    check("t1 running", running, 1);

    // Clamp: prescale 1 written while asleep becomes 3.
    sleep = 1'b1;
    @(negedge clkin);
    check("t2 sleep running", running, 0);
    check("t2 sleep pwm_cnt", pwm_cnt, 0);
    wr_pre(8'd1);
    check("t2 pre before apply", pre_active, 30);
    @(negedge clkin);
    check("t2 pre clamped", pre_active, 3);
    sleep = 1'b0;
    last_evt = cyc;
    push("t2 start", 1, 0, 1, 0, 3);
    push_steps("t2", 1, 9, 8, 3);
    drain();

    // Sleep at pwm_cnt=9.
    sleep = 1'b1;
    @(negedge clkin);
    check("t5 pwm_cnt", pwm_cnt, 0);
    check("t5 running", running, 0);
    check("t5 step", step, 0);
    ev = 0;
    repeat (20) begin
      @(negedge clkin);
      if (step || cycle_start || running) ev++;
    end
    check("t5 quiet", ev, 0);
    wr_pre(8'd30);
    @(negedge clkin);
    check("t5 pre restore", pre_active, 30);
    sleep = 1'b0;
    last_evt = cyc;
    push("t5 restart", 1, 0, 1, 0, 30);
    drain();
    check("t5 running", running, 1);

    // Deferred update: write 5 at pwm_cnt=7, applied at the wrap.
    push_steps("t3", 1, 7, 62, 30);
    drain();
    wr_pre(8'd5);
    check("t3 pre held", pre_active, 30);
    push_steps("t3", 8, 15, 62, 30);
    push("t3 wrap", 62, 0, 1, 1, 5);
    push("t3 cnt1 new", 12, 1, 0, 1, 5);
    drain();

    // Write landing exactly on the wrap edge stays pending for a full cycle.
    push_steps("t4", 2, 15, 12, 5);
    drain();
    repeat (11) @(negedge clkin);
    prescale_wr = 1'b1;
    prescale_in = 8'd10;
    @(negedge clkin);
    prescale_wr = 1'b0;
    check("t4 wrap step", step, 1);
    check("t4 wrap cycle_start", cycle_start, 1);
    check("t4 wrap pwm_cnt", pwm_cnt, 0);
    check("t4 wrap pre", pre_active, 5);
    last_evt = cyc;
    push_steps("t4b", 1, 15, 12, 5);
    push("t4b wrap", 12, 0, 1, 1, 10);
    push("t4b cnt1 new", 22, 1, 0, 1, 10);
    drain();

    // Reset mid-run with a pending write.
    push_steps("t6", 2, 5, 22, 10);
    drain();
    wr_pre(8'd7);
    sleep = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("t6 async pwm_cnt", pwm_cnt, 0);
    check("t6 async step", step, 0);
    check("t6 async cycle_start", cycle_start, 0);
    check("t6 async running", running, 0);
    check("t6 async pre", pre_active, 30);
    @(negedge clkin);
    reset = 1'b0;
    repeat (3) @(negedge clkin);
    check("t6 pending dropped", pre_active, 30);
    check("t6 stopped", running, 0);
    sleep = 1'b0;
    last_evt = cyc;
    push("t6 start", 1, 0, 1, 0, 30);
    push("t6 cnt1", 62, 1, 0, 1, 30);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
